// File: rtl/div_unit_pkg.sv
// Shared definitions for the multi-cycle divider and its E-stage glue.
package div_unit_pkg;

  // Divider control states, 2-bit encoding.
  typedef enum logic [1:0] {
    DivIdle = 2'd0,
    DivBusy = 2'd1,
    DivDone = 2'd2
  } div_state_e;

  // Fill bit for the divide-by-zero quotient (all ones at any width).
  localparam logic DivZeroFill = 1'b1;

  // SPECIAL-opcode function codes that select the divider in the E-stage glue.
  localparam logic [5:0] FunctDiv  = 6'b011010;
  localparam logic [5:0] FunctDivu = 6'b011011;

endpackage

// File: rtl/div_unit_iter.sv
// One restoring-division step: shift {rem, dvd} left, trial-subtract the divisor.
module div_iter #(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem,
  input  logic [WIDTH-1:0] dvd,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] rem_next,
  output logic [WIDTH-1:0] dvd_next,
  output logic             qbit
);

  logic [WIDTH:0] shifted;
  logic [WIDTH:0] trial;

  // rem < divisor on entry, so the shifted value and a negative trial both fit in WIDTH+1 bits
  // and trial[WIDTH] acts as the borrow/sign bit.
  always_comb begin
    shifted  = {rem, dvd[WIDTH-1]};
    trial    = shifted - {1'b0, divisor};
    qbit     = ~trial[WIDTH];
    rem_next = qbit ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];
    dvd_next = {dvd[WIDTH-2:0], qbit};
  end

endmodule

// File: rtl/div_unit.sv
// Multi-cycle radix-2 restoring divider (DIV/DIVU) with E-stage stall and annul.
module div_unit
  import div_unit_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = 6
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             start,
  input  logic             signed_div,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             annul,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder
);

  div_state_e state_q, state_d;

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] dvd_q, dvd_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic             signed_q, signed_d;
  logic             sign_a_q, sign_a_d;
  logic             sign_b_q, sign_b_d;
  logic             dbz_q, dbz_d;
  logic [WIDTH-1:0] quot_q, quot_d;
  logic [WIDTH-1:0] remd_q, remd_d;
  logic             done_q, done_d;

  logic             accept;
  logic             last_iter;
  logic             step;
  logic [WIDTH-1:0] rem_step, dvd_step;
  logic             qbit_step;
  logic [WIDTH-1:0] quot_fix, rem_fix;

  div_iter #(
    .WIDTH(WIDTH)
  ) u_iter (
    .rem     (rem_q),
    .dvd     (dvd_q),
    .divisor (dvs_q),
    .rem_next(rem_step),
    .dvd_next(dvd_step),
    .qbit    (qbit_step)
  );

  // Request acceptance, stall and final-iteration decode.
  always_comb begin
    accept    = start & ~annul & (state_q != DivBusy);
    busy      = (state_q == DivBusy) | accept;
    last_iter = (cnt_q == CNT_W'(WIDTH - 1));
    step      = (state_q == DivBusy) & ~annul;
  end

  // Sign fixup of the final step; divide-by-zero forces an all-ones quotient. The remainder
  // path alone already yields a for b == 0 (|a| re-negated when a was negative).
  always_comb begin
    quot_fix = (signed_q & (sign_a_q ^ sign_b_q)) ? -dvd_step : dvd_step;
    rem_fix  = (signed_q & sign_a_q) ? -rem_step : rem_step;
    if (dbz_q) quot_fix = {WIDTH{DivZeroFill}};
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      DivIdle: if (accept) state_d = DivBusy;
      DivBusy: begin
        if (annul) state_d = DivIdle;
        else if (last_iter) state_d = DivDone;
      end
      DivDone: state_d = accept ? DivBusy : DivIdle;
      default: state_d = DivIdle;
    endcase
  end

  // Datapath next-state: load on accept, iterate in BUSY, write result on the last step.
  always_comb begin
    cnt_d    = cnt_q;
    rem_d    = rem_q;
    dvd_d    = dvd_q;
    dvs_d    = dvs_q;
    signed_d = signed_q;
    sign_a_d = sign_a_q;
    sign_b_d = sign_b_q;
    dbz_d    = dbz_q;
    quot_d   = quot_q;
    remd_d   = remd_q;
    done_d   = 1'b0;
    if (accept) begin
      signed_d = signed_div;
      sign_a_d = a[WIDTH-1];
      sign_b_d = b[WIDTH-1];
      dvd_d    = (signed_div & a[WIDTH-1]) ? -a : a;
      dvs_d    = (signed_div & b[WIDTH-1]) ? -b : b;
      dbz_d    = (b == '0);
      rem_d    = '0;
      cnt_d    = '0;
    end else if (step) begin
      rem_d = rem_step;
      dvd_d = dvd_step;
      cnt_d = cnt_q + CNT_W'(1);
      if (last_iter) begin
        quot_d = quot_fix;
        remd_d = rem_fix;
        done_d = 1'b1;
      end
    end
  end

  // State register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state_q <= DivIdle;
    else         state_q <= state_d;
  end

  // Datapath and result registers.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt_q    <= '0;
      rem_q    <= '0;
      dvd_q    <= '0;
      dvs_q    <= '0;
      signed_q <= 1'b0;
      sign_a_q <= 1'b0;
      sign_b_q <= 1'b0;
      dbz_q    <= 1'b0;
      quot_q   <= '0;
      remd_q   <= '0;
      done_q   <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      rem_q    <= rem_d;
      dvd_q    <= dvd_d;
      dvs_q    <= dvs_d;
      signed_q <= signed_d;
      sign_a_q <= sign_a_d;
      sign_b_q <= sign_b_d;
      dbz_q    <= dbz_d;
      quot_q   <= quot_d;
      remd_q   <= remd_d;
      done_q   <= done_d;
    end
  end

  assign done      = done_q;
  assign quotient  = quot_q;
  assign remainder = remd_q;

endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit: directed table, corner sequences, random vs. model.
module tb_div_unit;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        start = 1'b0;
  logic        signed_div = 1'b0;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        annul = 1'b0;
  logic        busy;
  logic        done;
  logic [31:0] quotient;
  logic [31:0] remainder;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        sg;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] q;
    logic [31:0] r;
  } vec_t;

  vec_t vecs[10];

  div_unit #(
    .WIDTH(32),
    .CNT_W(6)
  ) dut (
    .clk       (clk),
    .resetn    (resetn),
    .start     (start),
    .signed_div(signed_div),
    .a         (a),
    .b         (b),
    .annul     (annul),
    .busy      (busy),
    .done      (done),
    .quotient  (quotient),
    .remainder (remainder)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: plain arithmetic; SV / and % truncate toward zero like DIV.
  function automatic void model(input logic sg, input logic [31:0] av, input logic [31:0] bv,
                                output logic [31:0] q, output logic [31:0] r);
    longint sa, sb;
    if (bv == 32'd0) begin
      q = 32'hFFFF_FFFF;
      r = av;
    end else if (sg) begin
      sa = longint'($signed(av));
      sb = longint'($signed(bv));
      q  = 32'(sa / sb);
      r  = 32'(sa % sb);
    end else begin
      q = av / bv;
      r = av % bv;
    end
  endfunction

  // One division with a single-cycle start; operands scrambled after acceptance.
  task automatic run_div(input logic sg, input logic [31:0] av, input logic [31:0] bv,
                         input logic [31:0] eq, input logic [31:0] er, input string name);
    int cyc;
    int busy_cnt;
    signed_div = sg;
    a = av;
    b = bv;
    start = 1'b1;
    #1;
    chk({name, " busy_at_start"}, busy, 1);
    tick();
    start = 1'b0;
    a = $urandom;
    b = $urandom;
    signed_div = 1'($urandom);
    busy_cnt = 1;
    cyc = 1;
    while (!done && cyc < 40) begin
      if (busy) busy_cnt++;
      tick();
      cyc++;
    end
    chk({name, " latency"}, cyc, 33);
    chk({name, " stall_cycles"}, busy_cnt, 33);
    chk({name, " quotient"}, quotient, eq);
    chk({name, " remainder"}, remainder, er);
    chk({name, " busy_in_done"}, busy, 0);
    tick();
    chk({name, " done_one_cycle"}, done, 0);
  endtask

  initial begin
    int cyc;
    int dones;
    logic [31:0] mq, mr, ra, rb;
    logic        rs;

    vecs[0] = '{1'b0, 32'd100,        32'd7,        32'd14,         32'd2};
    vecs[1] = '{1'b1, 32'hFFFF_FFF9,  32'd2,        32'hFFFF_FFFD,  32'hFFFF_FFFF};
    vecs[2] = '{1'b1, 32'd7,          32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1};
    vecs[3] = '{1'b1, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 32'd0};
    vecs[4] = '{1'b0, 32'hFFFF_FFFF,  32'd1,        32'hFFFF_FFFF,  32'd0};
    vecs[5] = '{1'b1, 32'd5,          32'd0,        32'hFFFF_FFFF,  32'd5};
    vecs[6] = '{1'b1, 32'hFFFF_FFFB,  32'd0,        32'hFFFF_FFFF,  32'hFFFF_FFFB};
    vecs[7] = '{1'b0, 32'd7,          32'd9,        32'd0,          32'd7};
    vecs[8] = '{1'b1, 32'hFFFF_FFF9,  32'hFFFF_FFFE, 32'd3,         32'hFFFF_FFFF};
    vecs[9] = '{1'b0, 32'h8000_0000,  32'hFFFF_FFFF, 32'd0,         32'h8000_0000};

    // Reset state
    tick();
    tick();
    chk("reset quotient", quotient, 0);
    chk("reset remainder", remainder, 0);
    chk("reset done", done, 0);
    chk("reset busy", busy, 0);
    resetn = 1'b1;
    tick();

    // Directed table
    for (int i = 0; i < 10; i++) begin
      run_div(vecs[i].sg, vecs[i].a, vecs[i].b, vecs[i].q, vecs[i].r, $sformatf("vec%0d", i));
    end

    // Annul mid-operation: no done, previous result kept
    run_div(1'b0, 32'd100, 32'd7, 32'd14, 32'd2, "pre_annul");
    signed_div = 1'b0;
    a = 32'd1000;
    b = 32'd3;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (9) tick();
    annul = 1'b1;
    tick();
    annul = 1'b0;
    chk("annul busy_after", busy, 0);
    chk("annul done_after", done, 0);
    dones = 0;
    for (int i = 0; i < 40; i++) begin
      if (done) dones++;
      tick();
    end
    chk("annul no_done", dones, 0);
    chk("annul quotient_kept", quotient, 14);
    chk("annul remainder_kept", remainder, 2);

    // annul together with start: request dropped
    start = 1'b1;
    annul = 1'b1;
    a = 32'd50;
    b = 32'd5;
    #1;
    chk("annul_start busy", busy, 0);
    tick();
    start = 1'b0;
    annul = 1'b0;
    chk("annul_start idle", busy, 0);
    run_div(1'b0, 32'd20, 32'd3, 32'd6, 32'd2, "after_annul");

    // Held start through BUSY gives exactly one result
    signed_div = 1'b1;
    a = 32'hFFFF_FF9C;
    b = 32'd7;
    start = 1'b1;
    dones = 0;
    for (int i = 0; i < 45; i++) begin
      tick();
      if (done) begin
        dones++;
        start = 1'b0;
      end
    end
    chk("held_start done_count", dones, 1);
    chk("held_start quotient", quotient, 32'hFFFF_FFF2);
    chk("held_start remainder", remainder, 32'hFFFF_FFFE);
    chk("held_start idle", busy, 0);

    // Back-to-back: new start in the DONE cycle
    signed_div = 1'b0;
    a = 32'd100;
    b = 32'd7;
    start = 1'b1;
    tick();
    start = 1'b0;
    cyc = 1;
    while (!done && cyc < 40) begin
      tick();
      cyc++;
    end
    chk("b2b first_latency", cyc, 33);
    chk("b2b first_quotient", quotient, 14);
    a = 32'd45;
    b = 32'd9;
    start = 1'b1;
    #1;
    chk("b2b busy_in_done", busy, 1);
    tick();
    start = 1'b0;
    chk("b2b accepted", busy, 1);
    cyc = 1;
    while (!done && cyc < 40) begin
      tick();
      cyc++;
    end
    chk("b2b second_latency", cyc, 33);
    chk("b2b quotient", quotient, 5);
    chk("b2b remainder", remainder, 0);
    tick();

    // Asynchronous reset mid-BUSY
    a = 32'd1000;
    b = 32'd3;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (5) tick();
    #2;
    resetn = 1'b0;
    #1;
    chk("async_reset quotient", quotient, 0);
    chk("async_reset remainder", remainder, 0);
    chk("async_reset busy", busy, 0);
    chk("async_reset done", done, 0);
    #3;
    resetn = 1'b1;
    tick();
    chk("post_reset idle", busy, 0);
    run_div(1'b0, 32'd9, 32'd4, 32'd2, 32'd1, "post_reset");

    // Randomized against the arithmetic model
    for (int i = 0; i < 60; i++) begin
      rs = 1'($urandom);
      ra = $urandom;
      rb = $urandom;
      case ($urandom_range(0, 5))
        0: rb = 32'($urandom_range(0, 15));
        1: rb = 32'd0;
        2: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
        3: rb = rb >> $urandom_range(0, 31);
        4: ra = ra >> $urandom_range(0, 31);
        default: ;
      endcase
      model(rs, ra, rb, mq, mr);
      run_div(rs, ra, rb, mq, mr, $sformatf("rand%0d", i));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
